// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: issues sequential word reads with up to MAX_OUTSTANDING in flight
// and buffers {pc, instr} pairs in a DEPTH-entry prefetch FIFO feeding decode.
module fetch_prefetch #(
  parameter int ADDR_W          = 32,
  parameter int INSTR_W         = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW;

  // Handshake: a request transfers on a rising edge where mem_req_valid && mem_req_ready;
  // while valid is high and not accepted, the address is held stable. Responses are never
  // back-pressured and arrive in request order, one per accepted request.

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic [OW-1:0]      outstanding, drop;
  logic [ADDR_W-1:0]  addr_q [MAX_OUTSTANDING];
  logic [QW-1:0]      aq_head, aq_tail;

  logic          accept, push, pop;
  logic [SW-1:0] credit_used;
  logic [OW-1:0] rsp_dec;

  wire unused_flush_bits = ^flush_addr[1:0];

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Credit counts both buffered words and in-flight reads (stale ones included),
  // so a returning response always finds room in the FIFO.
  assign credit_used   = SW'(count) + SW'(outstanding);
  assign mem_req_valid = !reset && !flush && (outstanding < OW'(MAX_OUTSTANDING))
                         && (credit_used < SW'(DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign accept  = mem_req_valid && mem_req_ready;
  assign push    = mem_rsp_valid && !flush && (drop == '0);
  assign out_valid = (count != '0);
  assign pop     = out_valid && !stall && !flush;
  assign rsp_dec = OW'(mem_rsp_valid);

  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      aq_head     <= '0;
      aq_tail     <= '0;
    end else begin
      // Stale responses still retire their tracked address, keeping the queue aligned.
      if (mem_rsp_valid) aq_head <= q_next(aq_head);
      if (flush) begin
        fetch_pc    <= {flush_addr[ADDR_W-1:2], 2'b00};
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        outstanding <= outstanding - rsp_dec;
        drop        <= outstanding - rsp_dec;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + ADDR_W'(4);
          aq_tail  <= q_next(aq_tail);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding + OW'(accept) - rsp_dec;
        if (mem_rsp_valid && (drop != '0)) drop <= drop - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && accept) addr_q[aq_tail] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]    <= addr_q[aq_head];
      fifo_instr[wr_ptr] <= mem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !pop) assert (count != CW'(DEPTH));
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed vector table, hand-written flush/wrap sequences and
// randomized traffic checked against an epoch-tagged queue model of the fetch stream.
module tb_fetch_prefetch;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic        stall, flush;
  logic [31:0] flush_addr;

  fetch_prefetch #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT),
                   .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .stall(stall), .flush(flush), .flush_addr(flush_addr)
  );

  always #5 clk = ~clk;

  // Reference model: memory requests tagged with the redirect epoch they were issued in;
  // a response reaches the FIFO only if its epoch is still current and no flush is active.
  typedef struct { int due; logic [31:0] addr; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  mreq_t mq[$];
  ent_t  fq[$];
  logic [31:0] fpc;
  int epoch, cyc, last_due;
  int n_vec = 0, n_err = 0;
  logic obs_ov, obs_rv, saw_wrap, wrap_mode, hold_pend;
  logic [31:0] obs_pc, obs_instr, obs_ra, hold_addr;

  typedef struct { logic stall; logic ov; logic [31:0] pc; logic rv; logic [31:0] ra; } vec_t;
  vec_t tbl[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flush_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(posedge clk); @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_req_valid", mem_req_valid, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cyc += 2;
    mq.delete(); fq.delete();
    fpc = RESET_PC; epoch = 0; last_due = cyc; hold_pend = 1'b0;
  endtask

  // One cycle: entered and left at a falling edge.
  task automatic step(input logic st, input logic fl, input logic [31:0] fa,
                      input logic rdy, input int lat);
    logic exp_rv, rsp_v;
    mreq_t r;
    int due;
    obs_ov = out_valid; obs_pc = out_pc; obs_instr = out_instr;
    chk("out_valid", out_valid, fq.size() != 0);
    if (fq.size() != 0 && out_valid) begin
      chk("out_pc", out_pc, fq[0].pc);
      chk("out_instr", out_instr, fq[0].instr);
    end
    stall = st; flush = fl; flush_addr = fa; mem_req_ready = rdy;
    rsp_v = (mq.size() != 0) && (mq[0].due <= cyc);
    mem_rsp_valid = rsp_v;
    mem_rsp_data  = rsp_v ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_rv = !fl && (mq.size() < MAX_OUT) && (fq.size() + mq.size() < DEPTH);
    if (hold_pend && !fl) begin
      chk("req_hold_valid", mem_req_valid, 1);
      chk("req_hold_addr", mem_req_addr, hold_addr);
    end
    chk("req_valid", mem_req_valid, exp_rv);
    if (exp_rv && mem_req_valid) chk("req_addr", mem_req_addr, fpc);
    obs_rv = mem_req_valid; obs_ra = mem_req_addr;
    hold_pend = exp_rv && !rdy; hold_addr = fpc;
    if (fq.size() != 0 && !st && !fl) void'(fq.pop_front());
    if (rsp_v) begin
      r = mq.pop_front();
      if (!fl && r.epoch == epoch) fq.push_back('{r.addr, mem_word(r.addr)});
    end
    if (exp_rv && rdy) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{due, fpc, epoch});
      last_due = due;
      if (wrap_mode && fpc == 32'h0) saw_wrap = 1'b1;
      fpc = fpc + 32'd4;
    end
    if (fl) begin
      fq.delete(); epoch++; fpc = fa & ~32'h3;
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
    logic seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 3);
      if (obs_ov) begin
        seen = 1'b1;
        chk(name, obs_pc, exp_pc);
        chk({name, "_instr"}, obs_instr, mem_word(exp_pc));
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; wrap_mode = 1'b0; saw_wrap = 1'b0;
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0C};
    tbl[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h14};
    tbl[6]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    tbl[8]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
    tbl[9]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h18};
    tbl[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
    @(negedge clk);
    do_reset();

    // 1-cycle memory, stall fills the FIFO then releases
    foreach (tbl[i]) begin
      step(tbl[i].stall, 1'b0, '0, 1'b1, 1);
      chk($sformatf("tbl%0d_ov", i), obs_ov, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), obs_instr, mem_word(tbl[i].pc));
      end
      chk($sformatf("tbl%0d_rv", i), obs_rv, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_ra", i), obs_ra, tbl[i].ra);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1, 1);

    // Longer memory latency, outstanding limit binds
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '0, 1'b1, 3);

    // Flush with two stale reads in flight; misaligned target
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h103, 1'b1, 3);
    chk("flush_ov_next", out_valid, 0);
    wait_first_pc("flush_first_pc", 32'h100);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1);

    // Flush coinciding with a response, then a second flush while drop is nonzero
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b0, '0, 1'b1, 5);
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h200, 1'b1, 3);
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h300, 1'b1, 3);
    wait_first_pc("dbl_flush_first_pc", 32'h300);

    // Address wrap with random ready gaps
    do_reset();
    wrap_mode = 1'b1;
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 3) == 0, 1'b0, '0, $urandom_range(0, 1) == 1, $urandom_range(1, 3));
    chk("addr_wrap_seen", saw_wrap, 1);
    wrap_mode = 1'b0;

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
           $urandom, $urandom_range(0, 3) != 0, $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
